// File: rtl/dpram_pkg.sv
// dpram_pkg: shared state type and elaboration helpers for dpram_avalon_clr
package dpram_pkg;
   typedef enum logic {CLEAR, READY} state_t;
   function automatic int be_width(input int dw);
      return dw / 8;
   endfunction
   function automatic bit latency_ok(input int rl);
      return rl == 1 || rl == 2;
   endfunction
endpackage

// File: rtl/dpram_avalon_clr_if.sv
// dpram_avalon_clr_if: one Avalon-MM port (address/read/write/byteenable/writedata in, readdata/readdatavalid/waitrequest out)
interface dpram_avalon_clr_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
);
   import dpram_pkg::*;
   localparam int BE_WIDTH = be_width(DATA_WIDTH);
   logic [ADDR_WIDTH-1:0] address;
   logic read;
   logic write;
   logic [BE_WIDTH-1:0] byteenable;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic readdatavalid;
   logic waitrequest;
   modport master(
      output address, read, write, byteenable, writedata,
      input readdata, readdatavalid, waitrequest
   );
   modport slave(
      input address, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/dpram_core.sv
// dpram_core: true dual-port byte-enabled RAM, synchronous read returning old data on mixed-port access
// ports: clk; per port (a_/b_): we, be, addr, wd in; q out (read data, one cycle after addr)
module dpram_core
   import dpram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                           clk,
   input  logic                           a_we,
   input  logic [be_width(DATA_WIDTH)-1:0] a_be,
   input  logic [ADDR_WIDTH-1:0]          a_addr,
   input  logic [DATA_WIDTH-1:0]          a_wd,
   output logic [DATA_WIDTH-1:0]          a_q,
   input  logic                           b_we,
   input  logic [be_width(DATA_WIDTH)-1:0] b_be,
   input  logic [ADDR_WIDTH-1:0]          b_addr,
   input  logic [DATA_WIDTH-1:0]          b_wd,
   output logic [DATA_WIDTH-1:0]          b_q
);
   localparam int BE_WIDTH = be_width(DATA_WIDTH);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk) begin
      a_q <= mem[a_addr];
      b_q <= mem[b_addr];
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wd[i*8 +: 8];
         if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wd[i*8 +: 8];
      end
   end
endmodule

// File: rtl/dpram_avalon_clr.sv
// dpram_avalon_clr: dual Avalon-MM port RAM with clear engine, collision flag and 1/2-cycle read latency
// ports: clk, reset_n (async low); clear_req in, busy out; collision out, collision_clr in;
//        a, b: dpram_avalon_clr_if.slave Avalon-MM ports
module dpram_avalon_clr
   import dpram_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 14,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear_req,
   output logic                    busy,
   output logic                    collision,
   input  logic                    collision_clr,
   dpram_avalon_clr_if.slave       a,
   dpram_avalon_clr_if.slave       b
);
   localparam int  BE_WIDTH = be_width(DATA_WIDTH);
   localparam bit  LAT_OK   = latency_ok(READ_LATENCY);
   localparam int  RL       = LAT_OK ? READ_LATENCY : 1;
   state_t state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic clr;
   logic coll;
   logic [1:0] wr;
   logic [1:0] rd;
   logic [1:0] v1;
   logic [1:0] v2;
   logic [BE_WIDTH-1:0] b_be;
   logic [DATA_WIDTH-1:0] q [2];
   logic [DATA_WIDTH-1:0] hold [2];
   assign clr = state == CLEAR;
   assign wr = {b.write, a.write} & {2{!busy}};
   // a write on the same port drops the read
   assign rd = {b.read & !b.write, a.read & !a.write} & {2{!busy}};
   assign coll = (&wr) && a.address == b.address;
   // on collision B only owns the lanes A leaves untouched
   assign b_be = b.byteenable & ~(coll ? a.byteenable : '0);
   assign a.waitrequest = busy;
   assign b.waitrequest = busy;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= CLEAR_ON_RESET ? CLEAR : READY;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (clr) begin
         cnt <= cnt + 1'b1;
         if (&cnt) begin
            state <= READY;
            busy  <= 1'b0;
         end
      end else if (clear_req) begin
         state <= CLEAR;
         busy  <= 1'b1;
      end else begin
         busy <= 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) collision <= 1'b0;
      else if (coll) collision <= 1'b1;
      else if (collision_clr) collision <= 1'b0;
   end
   dpram_core #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_core (
      .clk    (clk),
      .a_we   (clr | wr[0]),
      .a_be   (clr ? '1 : a.byteenable),
      .a_addr (clr ? cnt : a.address),
      .a_wd   (clr ? '0 : a.writedata),
      .a_q    (q[0]),
      .b_we   (wr[1]),
      .b_be   (b_be),
      .b_addr (b.address),
      .b_wd   (b.writedata),
      .b_q    (q[1])
   );
   // hold captures each delivered word: it is the held value at latency 1 and the output register at latency 2
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= '0;
         v2 <= '0;
         for (int p = 0; p < 2; p++) hold[p] <= '0;
      end else begin
         v1 <= rd;
         v2 <= v1;
         for (int p = 0; p < 2; p++) if (v1[p]) hold[p] <= q[p];
      end
   end
   assign a.readdatavalid = RL == 2 ? v2[0] : v1[0];
   assign b.readdatavalid = RL == 2 ? v2[1] : v1[1];
   assign a.readdata = RL == 2 ? hold[0] : (v1[0] ? q[0] : hold[0]);
   assign b.readdata = RL == 2 ? hold[1] : (v1[1] ? q[1] : hold[1]);
endmodule

// File: tb/tb_dpram_avalon_clr.sv
// tb_dpram_avalon_clr: scoreboard bench driving latency-1 and latency-2 instances with identical traffic
module tb_dpram_avalon_clr;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear_req = 1'b0;
   logic collision_clr = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
   logic [3:0] a_be = '0, b_be = '0;
   logic [31:0] a_wd = '0, b_wd = '0;
   logic [1:0] busy, coll;
   logic [3:0] vld, wreq;
   logic [31:0] rdat [4];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   dpram_avalon_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
   dpram_avalon_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
   dpram_avalon_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
   dpram_avalon_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();
   assign a1.address = a_addr; assign a2.address = a_addr; assign b1.address = b_addr; assign b2.address = b_addr;
   assign a1.read = a_rd; assign a2.read = a_rd; assign b1.read = b_rd; assign b2.read = b_rd;
   assign a1.write = a_wr; assign a2.write = a_wr; assign b1.write = b_wr; assign b2.write = b_wr;
   assign a1.byteenable = a_be; assign a2.byteenable = a_be; assign b1.byteenable = b_be; assign b2.byteenable = b_be;
   assign a1.writedata = a_wd; assign a2.writedata = a_wd; assign b1.writedata = b_wd; assign b2.writedata = b_wd;
   assign vld = {b2.readdatavalid, a2.readdatavalid, b1.readdatavalid, a1.readdatavalid};
   assign wreq = {b2.waitrequest, a2.waitrequest, b1.waitrequest, a1.waitrequest};
   assign rdat[0] = a1.readdata; assign rdat[1] = b1.readdata;
   assign rdat[2] = a2.readdata; assign rdat[3] = b2.readdata;
   dpram_avalon_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy[0]),
      .collision(coll[0]), .collision_clr(collision_clr), .a(a1), .b(b1));
   dpram_avalon_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .busy(busy[1]),
      .collision(coll[1]), .collision_clr(collision_clr), .a(a2), .b(b2));
   // reference model: word array, clear countdown, sticky flag; expected reads queued per (instance, port)
   typedef struct {logic [31:0] d; int t;} exp_t;
   exp_t sb [4][$];
   exp_t e;
   logic [31:0] mem [DEPTH];
   int clr_left = DEPTH;
   int cyc = 0;
   bit coll_m = 1'b0;
   bit rdy;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_left = DEPTH;
         coll_m = 1'b0;
         for (int k = 0; k < 4; k++) sb[k].delete();
      end else begin
         rdy = clr_left == 0;
         if (!rdy) begin
            mem[DEPTH-clr_left] = '0;
            clr_left--;
         end else begin
            if (a_rd && !a_wr) begin
               sb[0].push_back('{mem[a_addr], cyc + 1});
               sb[2].push_back('{mem[a_addr], cyc + 2});
            end
            if (b_rd && !b_wr) begin
               sb[1].push_back('{mem[b_addr], cyc + 1});
               sb[3].push_back('{mem[b_addr], cyc + 2});
            end
            for (int i = 0; i < 4; i++) begin
               if (b_wr && b_be[i] && !(a_wr && a_addr == b_addr && a_be[i])) mem[b_addr][i*8 +: 8] = b_wd[i*8 +: 8];
               if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] = a_wd[i*8 +: 8];
            end
            if (clear_req) clr_left = DEPTH;
         end
         if (rdy && a_wr && b_wr && a_addr == b_addr) coll_m = 1'b1;
         else if (collision_clr) coll_m = 1'b0;
         cyc++;
      end
   end
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at cycle %0d", nm, got, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk("busy", 32'(busy[d]), 32'(clr_left > 0));
         chk("collision", 32'(coll[d]), 32'(coll_m));
      end
      for (int k = 0; k < 4; k++) begin
         chk("waitrequest", 32'(wreq[k]), 32'(clr_left > 0));
         if (vld[k]) begin
            if (sb[k].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid port %0d got data %h want no valid at cycle %0d", k, rdat[k], cyc);
            end else begin
               e = sb[k].pop_front();
               chk($sformatf("readdata[%0d]", k), rdat[k], e.d);
               chk($sformatf("latency[%0d]", k), 32'(cyc), 32'(e.t));
            end
         end
      end
   end
   task automatic idle();
      a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0; clear_req = 0; collision_clr = 0;
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask
   task automatic a_op(input bit r, input bit w, input int addr, input logic [3:0] be, input logic [31:0] wd);
      a_rd = r; a_wr = w; a_addr = 4'(addr); a_be = be; a_wd = wd;
   endtask
   task automatic b_op(input bit r, input bit w, input int addr, input logic [3:0] be, input logic [31:0] wd);
      b_rd = r; b_wr = w; b_addr = 4'(addr); b_be = be; b_wd = wd;
   endtask
   task automatic measure_clear(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy[0] && n < 200);
      chk(nm, 32'(n), 32'd16);
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((busy[0] || busy[1]) && n < 100) begin
         tick();
         n++;
      end
      chk("wait_ready_bound", 32'(n < 100), 32'd1);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      idle();
      tick(3);
      #2 reset_n = 1'b1;
      measure_clear("reset_clear_len");
      for (int i = 0; i < DEPTH; i++) begin a_op(1, 0, i, 4'h0, 0); tick(); end
      idle(); tick(3);
      a_op(0, 1, 5, 4'hF, 32'hDEADBEEF); tick();
      a_op(0, 1, 5, 4'b0101, 32'h11223344); tick();
      a_op(1, 0, 5, 4'h0, 0); tick();
      idle(); tick(3);
      a_op(0, 1, 3, 4'hF, 32'hAAAA5555); b_op(1, 0, 3, 4'h0, 0); tick();
      idle(); b_op(1, 0, 3, 4'h0, 0); tick();
      idle(); tick(3);
      a_op(0, 1, 7, 4'b0001, 32'h000000FF); b_op(0, 1, 7, 4'hF, 32'h12345678); tick();
      idle();
      chk("collision_set_1", 32'(coll[0]), 32'd1);
      chk("collision_set_2", 32'(coll[1]), 32'd1);
      a_op(1, 0, 7, 4'h0, 0); tick();
      idle(); tick(2);
      collision_clr = 1'b1; tick();
      collision_clr = 1'b0;
      chk("collision_clr_1", 32'(coll[0]), 32'd0);
      chk("collision_clr_2", 32'(coll[1]), 32'd0);
      for (int i = 0; i < 4; i++) begin a_op(0, 1, i, 4'hF, 32'(i + 1)); tick(); end
      idle();
      for (int i = 0; i < 4; i++) begin b_op(1, 0, i, 4'h0, 0); tick(); end
      idle(); tick(4);
      repeat (400) begin
         a_op($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7), 4'($urandom), $urandom);
         b_op($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7), 4'($urandom), $urandom);
         clear_req = $urandom_range(0, 99) == 0;
         collision_clr = $urandom_range(0, 19) == 0;
         tick();
      end
      idle(); tick(3);
      wait_idle();
      clear_req = 1'b1; tick();
      clear_req = 1'b0;
      tick(7);
      a_op(1, 0, 2, 4'h0, 0);
      #2 reset_n = 1'b0;
      tick();
      idle();
      #2 reset_n = 1'b1;
      measure_clear("restart_clear_len");
      for (int i = 0; i < DEPTH; i++) begin a_op(0, 1, i, 4'hF, 32'($urandom) | 32'h1); tick(); end
      idle();
      clear_req = 1'b1; tick();
      clear_req = 1'b0;
      chk("clear_req_busy_1", 32'(busy[0]), 32'd1);
      chk("clear_req_busy_2", 32'(busy[1]), 32'd1);
      wait_idle();
      for (int i = 0; i < DEPTH; i++) begin a_op(1, 0, i, 4'h0, 0); b_op(1, 0, DEPTH - 1 - i, 4'h0, 0); tick(); end
      idle(); tick(4);
      for (int k = 0; k < 4; k++) chk($sformatf("drain[%0d]", k), 32'(sb[k].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dpram_avalon_clr.md
Name: dpram_avalon_clr

Overview:
- Parametrised successor to the fixed 16K x 32 dual-port on-chip memory used by the CPU SoC.
- Two symmetric Avalon-MM slave ports (A, B) on one clock, with:
  - configurable width, depth and read latency;
  - explicit readdatavalid/waitrequest handshakes;
  - a hardware clear engine that zeroes the array after reset or on request;
  - defined mixed-port collision handling with a sticky collision flag.
- Sits between CPU instruction/data masters and the RAM; replaces direct RAM instantiation.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 14: word address width; DEPTH = 2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read acceptance to readdatavalid; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1: 1 = zero whole array after reset release; 0 = ready immediately.

Ports:
- clk  in  1  single clock for both ports.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; starts a clear when the block is READY.
- busy  out  1  high while clearing.
- collision  out  1  sticky; set on a same-cycle, same-address write from both ports.
- collision_clr  in  1  clears collision.
- a_address / b_address  in  ADDR_WIDTH  word address.
- a_read / b_read  in  1  read request.
- a_write / b_write  in  1  write request.
- a_byteenable / b_byteenable  in  DATA_WIDTH/8  byte lane enables for writes.
- a_writedata / b_writedata  in  DATA_WIDTH  write data.
- a_readdata / b_readdata  out  DATA_WIDTH  read data.
- a_readdatavalid / b_readdatavalid  out  1  read data valid.
- a_waitrequest / b_waitrequest  out  1  request not accepted this cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - readdata = 0, readdatavalid = 0, collision = 0, clear counter = 0.
  - busy = 1 and waitrequest = 1 on both ports.
  - Array contents are not reset.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - CLEAR: write 0 to address = counter with all byte lanes; counter += 1 each cycle.
    - The cycle that writes DEPTH-1 is the last CLEAR cycle; next state is READY and counter returns to 0.
    - A clear therefore takes exactly DEPTH cycles.
  - READY: busy = 0 and waitrequest = 0 on both ports.
    - clear_req = 1 moves to CLEAR on the next edge.
    - A request accepted in that same cycle still completes.
  - In CLEAR, busy = 1 and waitrequest = 1 on both ports; no reads or writes are accepted, and clear_req is ignored.
- Acceptance: a request is accepted when (read or write) and waitrequest = 0.
- Write:
  - Only lanes with byteenable = 1 are updated, at the edge ending the accept cycle.
  - If read and write are both set, the write wins and the read is dropped (no readdatavalid).
- Read:
  - Data appears with readdatavalid = 1 exactly READ_LATENCY cycles after acceptance; one valid pulse per accepted read.
  - Back-to-back reads give a continuous readdatavalid stream.
  - readdata holds its last value while readdatavalid = 0.
- Ordering:
  - Same port: write at cycle N, read same address at cycle N+1 returns the new data.
  - Mixed port, same cycle: a read on one port to the address the other port writes returns the OLD data.
- Dual write collision: both ports write the same address in the same cycle.
  - Port A's enabled lanes win.
  - Port B's lanes not enabled by A are written from B.
  - collision is set on the next edge and stays set until collision_clr.
  - If set and clear coincide, set wins.
- Reset mid-clear: counter restarts from 0; the read pipeline is flushed, so no stale readdatavalid appears after reset.
- Address: no wrap logic is needed; the address width exactly covers DEPTH.

Decomposition:
- Shared package dpram_pkg:
  - state enum (CLEAR, READY);
  - localparam function computing BE_WIDTH = DATA_WIDTH/8;
  - READ_LATENCY legality check constant.
- Sub-module dpram_core: inferred true-dual-port, byte-enabled, old-data mixed-port RAM array with unregistered outputs, parametrised by DATA_WIDTH/ADDR_WIDTH.
- The top level holds:
  - the FSM and clear counter;
  - the port-A mux between clear and user traffic;
  - the collision lane merge;
  - the READ_LATENCY-deep valid/data pipelines.

Test Plan:
- Reset-clear: CLEAR_ON_RESET = 1, ADDR_WIDTH = 4, reset_n released. Required response:
  - busy and waitrequest high for exactly 16 cycles, then low;
  - reading all 16 addresses returns 0x00000000.
- Byte-enable write: write 0xDEADBEEF to A addr 5, then A write 0x11223344 with byteenable 4'b0101; A read addr 5, READ_LATENCY = 1. Required response: a_readdatavalid exactly 1 cycle later, data 0xDE22BE44.
- Mixed-port ordering: A writes 0xAAAA5555 to addr 3 while B reads addr 3 in the same cycle (old value 0). Required response:
  - B returns 0x00000000;
  - a B read on the next cycle returns 0xAAAA5555.
- Dual write collision:
  - Stimulus: A writes 0x000000FF with byteenable 4'b0001 and B writes 0x12345678 with byteenable 4'b1111, both to addr 7.
  - Required response: collision = 1 next cycle, and a read gives 0x123456FF.
  - Then pulse collision_clr; collision returns to 0.
- READ_LATENCY = 2 streaming: 4 back-to-back B reads of addrs 0..3 holding values 1..4. Required response: readdatavalid high for 4 consecutive cycles starting 2 cycles after the first accept, with data 1,2,3,4.
- Reset mid-clear and clear_req:
  - Assert reset_n low at clear cycle 8 with a read in flight. Required response: no readdatavalid appears, and a full 16-cycle clear restarts.
  - Later, pulse clear_req in READY after writing nonzero data. Required response: busy asserts on the next cycle and the memory reads back zero.
